// File: rtl/dfu_flash_sequencer.sv
// DFU block sequencer: turns DNLOAD/UPLOAD block transactions into page-granular
// requests for the USB SPI flash bridge, with write-completion tracking and an upload skid FIFO.
module dfu_flash_sequencer #(
  parameter int          PAGE_SIZE  = 256,
  parameter logic [15:0] BASE_PAGE  = 16'h0200,
  parameter logic [15:0] NUM_PAGES  = 16'h0400,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dn_start,
  input  logic [15:0] dn_block,
  input  logic [8:0]  dn_length,
  input  logic [7:0]  dn_data,
  input  logic        dn_valid,
  output logic        dn_ready,
  input  logic        up_start,
  input  logic [15:0] up_block,
  input  logic [8:0]  up_length,
  output logic [7:0]  up_data,
  output logic        up_valid,
  input  logic        up_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] flash_address,
  output logic        flash_rd_request,
  output logic        flash_rd_data_free,
  input  logic        flash_rd_data_put,
  input  logic [7:0]  flash_rd_data,
  output logic        flash_wr_request,
  input  logic        flash_wr_busy,
  output logic        flash_wr_data_avail,
  input  logic        flash_wr_data_get,
  output logic [7:0]  flash_wr_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_STREAM = 3'd1;
  localparam logic [2:0] S_WR_WAIT   = 3'd2;
  localparam logic [2:0] S_RD_STREAM = 3'd3;
  localparam logic [2:0] S_RD_DRAIN  = 3'd4;

  localparam int              PW           = $clog2(FIFO_DEPTH);
  localparam int              CW           = $clog2(FIFO_DEPTH + 1);
  localparam logic [8:0]      LP_PAGE_SIZE = 9'(PAGE_SIZE);
  localparam logic [CW-1:0]   LP_FREE_MAX  = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0]   LP_FULL      = CW'(FIFO_DEPTH);

  logic [2:0]    r_state;
  logic [8:0]    r_length;
  logic [8:0]    r_byte_count;
  logic [15:0]   r_address;
  logic          r_done;
  logic          r_error;
  logic          r_wr_request;
  logic          r_rd_request;
  logic          r_busy_seen;
  logic [2:0]    r_wait_cnt;
  logic [7:0]    r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_fifo_count;

  logic w_wr_stream;
  logic w_wr_avail;
  logic w_wr_get;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_put;
  logic w_put_bad;
  logic w_push;
  logic w_pop;
  logic w_dn_bad;
  logic w_up_bad;

  assign w_wr_stream  = (r_state == S_WR_STREAM);
  assign w_wr_avail   = w_wr_stream && dn_valid && (r_byte_count < r_length);
  assign w_wr_get     = w_wr_avail && flash_wr_data_get;
  assign w_fifo_empty = (r_fifo_count == '0);
  assign w_fifo_full  = (r_fifo_count == LP_FULL);
  assign w_put        = flash_rd_data_put && ((r_state == S_RD_STREAM) || (r_state == S_RD_DRAIN));
  // A put past the requested length or into a full FIFO is dropped and flagged.
  assign w_put_bad    = w_put && ((r_byte_count >= r_length) || w_fifo_full);
  assign w_push       = w_put && !w_put_bad;
  assign w_pop        = !w_fifo_empty && up_ready;
  assign w_dn_bad     = (dn_length > LP_PAGE_SIZE) || (dn_block >= NUM_PAGES);
  assign w_up_bad     = (up_length == 9'd0) || (up_length > LP_PAGE_SIZE) || (up_block >= NUM_PAGES);

  assign dn_ready            = w_wr_get;
  assign flash_wr_data_avail = w_wr_avail;
  assign flash_wr_data       = w_wr_stream ? dn_data : 8'd0;
  assign flash_wr_request    = r_wr_request;
  assign flash_rd_request    = r_rd_request;
  assign flash_rd_data_free  = (r_state == S_RD_STREAM) && (r_fifo_count <= LP_FREE_MAX) &&
                               (r_byte_count < r_length);
  assign flash_address       = r_address;
  assign up_valid            = !w_fifo_empty;
  assign up_data             = w_fifo_empty ? 8'd0 : r_fifo_mem[r_rd_ptr];
  assign busy                = (r_state != S_IDLE);
  assign done                = r_done;
  assign error               = r_error;

  // NOTE: storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= flash_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_length     <= '0;
      r_byte_count <= '0;
      r_address    <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_wr_request <= 1'b0;
      r_rd_request <= 1'b0;
      r_busy_seen  <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_put_bad) r_error <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (dn_start) begin
            if (dn_length == 9'd0) begin
              r_error <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_dn_bad) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_address    <= BASE_PAGE + dn_block;
              r_length     <= dn_length;
              r_byte_count <= '0;
              r_error      <= 1'b0;
              r_wr_request <= 1'b1;
              r_state      <= S_WR_STREAM;
            end
          end else if (up_start) begin
            if (w_up_bad) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_address    <= BASE_PAGE + up_block;
              r_length     <= up_length;
              r_byte_count <= '0;
              r_error      <= 1'b0;
              r_rd_request <= 1'b1;
              r_state      <= S_RD_STREAM;
            end
          end
        end
        S_WR_STREAM: begin
          if (w_wr_get) begin
            r_byte_count <= r_byte_count + 9'd1;
            if (r_byte_count + 9'd1 == r_length) begin
              r_wr_request <= 1'b0;
              r_busy_seen  <= 1'b0;
              r_wait_cnt   <= '0;
              r_state      <= S_WR_WAIT;
            end
          end
        end
        S_WR_WAIT: begin
          // The bridge must show busy within eight cycles or the program is deemed lost.
          if (flash_wr_busy) begin
            r_busy_seen <= 1'b1;
          end else if (r_busy_seen) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_wait_cnt == 3'd7) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        S_RD_STREAM: begin
          if (w_push) begin
            r_byte_count <= r_byte_count + 9'd1;
            if (r_byte_count + 9'd1 == r_length) begin
              r_rd_request <= 1'b0;
              r_state      <= S_RD_DRAIN;
            end
          end
        end
        S_RD_DRAIN: begin
          if (w_fifo_empty) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfu_flash_sequencer.sv
// Directed bench for dfu_flash_sequencer: the bench plays DFU handler, flash bridge and
// upload consumer cycle by cycle and compares against hand-computed expectations.
module tb_dfu_flash_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dn_start, dn_valid, dn_ready;
  logic [15:0] dn_block;
  logic [8:0]  dn_length;
  logic [7:0]  dn_data;
  logic        up_start, up_valid, up_ready;
  logic [15:0] up_block;
  logic [8:0]  up_length;
  logic [7:0]  up_data;
  logic        busy, done, error;
  logic [15:0] flash_address;
  logic        flash_rd_request, flash_rd_data_free, flash_rd_data_put;
  logic [7:0]  flash_rd_data;
  logic        flash_wr_request, flash_wr_busy, flash_wr_data_avail, flash_wr_data_get;
  logic [7:0]  flash_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dfu_flash_sequencer dut (
    .clk(clk), .reset(reset),
    .dn_start(dn_start), .dn_block(dn_block), .dn_length(dn_length), .dn_data(dn_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready),
    .up_start(up_start), .up_block(up_block), .up_length(up_length), .up_data(up_data),
    .up_valid(up_valid), .up_ready(up_ready),
    .busy(busy), .done(done), .error(error), .flash_address(flash_address),
    .flash_rd_request(flash_rd_request), .flash_rd_data_free(flash_rd_data_free),
    .flash_rd_data_put(flash_rd_data_put), .flash_rd_data(flash_rd_data),
    .flash_wr_request(flash_wr_request), .flash_wr_busy(flash_wr_busy),
    .flash_wr_data_avail(flash_wr_data_avail), .flash_wr_data_get(flash_wr_data_get),
    .flash_wr_data(flash_wr_data)
  );

  function automatic logic [7:0] dpat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [7:0] upat(input int i);
    return 8'((i ^ 8'hA5) & 255);
  endfunction

  function automatic logic [40:0] all_outs();
    return {dn_ready, up_data, up_valid, busy, done, error, flash_address, flash_rd_request,
            flash_rd_data_free, flash_wr_request, flash_wr_data_avail, flash_wr_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a DNLOAD start and streams bytes with the bridge taking every available byte.
  task automatic do_dn_stream(input logic [15:0] blk, input logic [8:0] len, input bit toggle,
                              output logic [15:0] addr, output int n_gets, output int n_bad,
                              output int n_req_bad, output logic avail_after,
                              output logic req_after);
    int sent;
    int cyc;
    n_bad = 0; n_req_bad = 0;
    dn_start = 1'b1; dn_block = blk; dn_length = len;
    step();
    dn_start = 1'b0;
    addr = flash_address;
    sent = 0; cyc = 0;
    while (sent < int'(len) && cyc < 2000) begin
      if (flash_wr_request !== 1'b1) n_req_bad++;
      dn_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      dn_data  = dpat(sent);
      #1;
      flash_wr_data_get = flash_wr_data_avail;
      #1;
      if (flash_wr_data_get) begin
        if (flash_wr_data !== dpat(sent) || dn_ready !== 1'b1 || dn_valid !== 1'b1) n_bad++;
        sent++;
      end
      step();
      cyc++;
    end
    flash_wr_data_get = 1'b0;
    dn_valid = 1'b1;
    #1;
    avail_after = flash_wr_data_avail;
    req_after   = flash_wr_request;
    dn_valid = 1'b0;
    n_gets = sent;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (all_outs() !== 41'd0) begin n_errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    reset = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_dnload(input logic [15:0] blk, input logic [8:0] len, input bit toggle,
                             input int busy_cycles);
    logic [15:0] addr;
    int gets, bad, reqbad, early, lat;
    logic av_after, rq_after;
    do_dn_stream(blk, len, toggle, addr, gets, bad, reqbad, av_after, rq_after);
    n_checks++; if (addr !== 16'h0200 + blk) begin n_errors++; $display("FAIL dn_addr: got %h expected %h", addr, 16'h0200 + blk); end
    n_checks++; if (gets != int'(len)) begin n_errors++; $display("FAIL dn_gets: got %0d expected %0d", gets, len); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL dn_byte_order: got %0d bad bytes expected 0", bad); end
    n_checks++; if (reqbad != 0) begin n_errors++; $display("FAIL dn_req_held: got %0d low cycles expected 0", reqbad); end
    n_checks++; if (av_after !== 1'b0) begin n_errors++; $display("FAIL dn_no_extra_avail: got %b expected 0", av_after); end
    n_checks++; if (rq_after !== 1'b0) begin n_errors++; $display("FAIL dn_req_drop: got %b expected 0", rq_after); end
    step(); step();
    flash_wr_busy = 1'b1;
    early = 0;
    repeat (busy_cycles) begin step(); if (done !== 1'b0 || busy !== 1'b1) early++; end
    flash_wr_busy = 1'b0;
    n_checks++; if (early != 0) begin n_errors++; $display("FAIL dn_wait_busy: got %0d bad cycles expected 0", early); end
    lat = 0;
    while (lat < 20) begin step(); lat++; if (done === 1'b1) break; end
    n_checks++; if (lat != 1) begin n_errors++; $display("FAIL dn_done_latency: got %0d expected 1", lat); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL dn_error: got %b expected 0", error); end
    step();
    n_checks++; if ({done, busy} !== 2'b00) begin n_errors++; $display("FAIL dn_done_pulse: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_zero_and_bad();
    int req_seen;
    dn_start = 1'b1; dn_block = 16'd3; dn_length = 9'd0;
    step();
    dn_start = 1'b0;
    n_checks++; if ({done, busy, flash_wr_request, error} !== 4'b1000) begin n_errors++; $display("FAIL zero_len: got %b expected 1000", {done, busy, flash_wr_request, error}); end
    req_seen = 0;
    repeat (4) begin step(); if (flash_wr_request !== 1'b0 || done !== 1'b0) req_seen++; end
    n_checks++; if (req_seen != 0) begin n_errors++; $display("FAIL zero_len_quiet: got %0d cycles expected 0", req_seen); end
    dn_start = 1'b1; dn_block = 16'h0400; dn_length = 9'd10;
    step();
    dn_start = 1'b0;
    n_checks++; if ({error, done, busy, flash_wr_request, flash_rd_request} !== 5'b11000) begin n_errors++; $display("FAIL bad_block: got %b expected 11000", {error, done, busy, flash_wr_request, flash_rd_request}); end
    step();
    n_checks++; if ({error, done} !== 2'b10) begin n_errors++; $display("FAIL error_sticky: got %b expected 10", {error, done}); end
    dn_start = 1'b1; dn_block = 16'h03FF; dn_length = 9'd257;
    step();
    dn_start = 1'b0;
    n_checks++; if ({error, done, busy} !== 3'b110) begin n_errors++; $display("FAIL dn_len_257: got %b expected 110", {error, done, busy}); end
    up_start = 1'b1; up_block = 16'd0; up_length = 9'd0;
    step();
    up_start = 1'b0;
    n_checks++; if ({error, done, busy, flash_rd_request} !== 4'b1100) begin n_errors++; $display("FAIL up_len_0: got %b expected 1100", {error, done, busy, flash_rd_request}); end
    step();
  endtask

  task automatic test_wr_timeout();
    logic [15:0] addr;
    int gets, bad, reqbad, lat;
    logic av_after, rq_after;
    do_dn_stream(16'd1, 9'd1, 1'b0, addr, gets, bad, reqbad, av_after, rq_after);
    n_checks++; if ({error, busy} !== 2'b01) begin n_errors++; $display("FAIL timeout_start: got %b expected 01", {error, busy}); end
    lat = 0;
    while (lat < 30) begin step(); lat++; if (done === 1'b1) break; end
    n_checks++; if (lat != 8) begin n_errors++; $display("FAIL timeout_latency: got %0d expected 8", lat); end
    n_checks++; if ({error, busy} !== 2'b10) begin n_errors++; $display("FAIL timeout_error: got %b expected 10", {error, busy}); end
    step();
  endtask

  task automatic test_upload();
    int cyc, puts, pops, occ, max_occ, bad_free, extra_req, bad_valid, bad_data;
    bit put_now, pop_now;
    up_start = 1'b1; up_block = 16'd0; up_length = 9'd16;
    step();
    up_start = 1'b0;
    n_checks++; if ({flash_address, flash_rd_request, busy, error} !== {16'h0200, 3'b110}) begin n_errors++; $display("FAIL up_start: got %h/%b expected 0200/110", flash_address, {flash_rd_request, busy, error}); end
    cyc = 0; puts = 0; pops = 0; occ = 0; max_occ = 0;
    bad_free = 0; extra_req = 0; bad_valid = 0; bad_data = 0;
    while (pops < 16 && cyc < 500) begin
      up_ready = (cyc >= 20);
      put_now = flash_rd_data_free;
      flash_rd_data_put = put_now;
      flash_rd_data = upat(puts);
      #1;
      if (put_now && occ >= 3) bad_free++;
      if (put_now && puts >= 16) extra_req++;
      if (up_valid !== (occ > 0)) bad_valid++;
      pop_now = up_valid && up_ready;
      if (pop_now && up_data !== upat(pops)) bad_data++;
      step();
      if (put_now) puts++;
      if (pop_now) pops++;
      occ = occ + int'(put_now) - int'(pop_now);
      if (occ > max_occ) max_occ = occ;
      cyc++;
    end
    flash_rd_data_put = 1'b0;
    up_ready = 1'b0;
    n_checks++; if (puts != 16 || pops != 16) begin n_errors++; $display("FAIL up_counts: got puts=%0d pops=%0d expected 16/16", puts, pops); end
    n_checks++; if (bad_free != 0 || max_occ > 3) begin n_errors++; $display("FAIL up_free_margin: got %0d bad, max fill %0d expected 0, <=3", bad_free, max_occ); end
    n_checks++; if (extra_req != 0) begin n_errors++; $display("FAIL up_no_17th: got %0d expected 0", extra_req); end
    n_checks++; if (bad_valid != 0) begin n_errors++; $display("FAIL up_valid: got %0d bad cycles expected 0", bad_valid); end
    n_checks++; if (bad_data != 0) begin n_errors++; $display("FAIL up_data_order: got %0d bad bytes expected 0", bad_data); end
    n_checks++; if ({flash_rd_request, done, busy} !== 3'b001) begin n_errors++; $display("FAIL up_drain: got %b expected 001", {flash_rd_request, done, busy}); end
    step();
    n_checks++; if ({done, busy, error} !== 3'b100) begin n_errors++; $display("FAIL up_done: got %b expected 100", {done, busy, error}); end
    step();
  endtask

  task automatic test_collision_and_reset();
    int av_bad;
    error_prev_check: begin
      dn_start = 1'b1; dn_block = 16'd5; dn_length = 9'd4;
      up_start = 1'b1; up_block = 16'd1; up_length = 9'd4;
    end
    step();
    dn_start = 1'b0; up_start = 1'b0;
    n_checks++; if ({flash_wr_request, flash_rd_request, error, flash_address} !== {3'b100, 16'h0205}) begin n_errors++; $display("FAIL collision: got %b/%h expected 100/0205", {flash_wr_request, flash_rd_request, error}, flash_address); end
    av_bad = 0;
    repeat (2) begin
      dn_valid = 1'b1; dn_data = 8'h5A;
      #1;
      flash_wr_data_get = flash_wr_data_avail;
      if (flash_wr_data_avail !== 1'b1) av_bad++;
      step();
    end
    n_checks++; if (av_bad != 0 || busy !== 1'b1) begin n_errors++; $display("FAIL mid_stream: got %0d stalls busy=%b expected 0/1", av_bad, busy); end
    reset = 1'b1; dn_valid = 1'b1; flash_wr_data_get = 1'b1; dn_data = 8'hFF; up_ready = 1'b1;
    step();
    n_checks++; if (all_outs() !== 41'd0) begin n_errors++; $display("FAIL reset_mid_stream: got %h expected 0", all_outs()); end
    reset = 1'b0; dn_valid = 1'b0; flash_wr_data_get = 1'b0; up_ready = 1'b0;
    step();
    n_checks++; if ({busy, flash_rd_request, flash_wr_request} !== 3'b000) begin n_errors++; $display("FAIL post_reset_idle: got %b expected 000", {busy, flash_rd_request, flash_wr_request}); end
  endtask

  initial begin
    reset = 1'b1;
    dn_start = 1'b0; dn_block = '0; dn_length = '0; dn_data = '0; dn_valid = 1'b0;
    up_start = 1'b0; up_block = '0; up_length = '0; up_ready = 1'b0;
    flash_rd_data_put = 1'b0; flash_rd_data = '0;
    flash_wr_busy = 1'b0; flash_wr_data_get = 1'b0;
    test_reset();
    test_dnload(16'd3, 9'd256, 1'b0, 50);
    test_dnload(16'd7, 9'd100, 1'b1, 10);
    test_zero_and_bad();
    test_wr_timeout();
    test_upload();
    test_collision_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dfu_flash_sequencer.md
Name: dfu_flash_sequencer

Overview:
- Sits directly upstream of the USB SPI flash bridge.
- Converts DFU DNLOAD/UPLOAD block transactions from the DFU class handler into page-granular bridge requests: page address mapping, byte streaming with handshakes, write-completion tracking, and read-side buffering.
- One DFU block maps to one flash page; the image region starts at BASE_PAGE.

Parameters:
PAGE_SIZE, 256, bytes per flash page and maximum DFU block length
BASE_PAGE, 16'h0200, first flash page of the DFU image region
NUM_PAGES, 16'h0400, pages in image region; blocks >= NUM_PAGES rejected
FIFO_DEPTH, 4, upload skid FIFO entries (power of two, >= 4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
dn_start  in  1  pulse: begin DNLOAD of dn_block
dn_block  in  16  DFU block number
dn_length  in  9  bytes in block, 0..PAGE_SIZE; 0 = end of download
dn_data  in  8  download byte
dn_valid  in  1  dn_data valid
dn_ready  out  1  byte accepted when dn_valid && dn_ready
up_start  in  1  pulse: begin UPLOAD of up_block
up_block  in  16  DFU block number
up_length  in  9  bytes requested, 1..PAGE_SIZE
up_data  out  8  upload byte
up_valid  out  1  up_data valid
up_ready  in  1  consumer accepts
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at transaction end
error  out  1  sticky until next accepted start
flash_address  out  16  bridge page address
flash_rd_request  out  1  bridge read request
flash_rd_data_free  out  1  space for another byte
flash_rd_data_put  in  1  bridge byte strobe
flash_rd_data  in  8  bridge read byte
flash_wr_request  out  1  bridge write request
flash_wr_busy  in  1  bridge erase/program in progress
flash_wr_data_avail  out  1  byte available to bridge
flash_wr_data_get  in  1  bridge consumed byte
flash_wr_data  out  8  byte to bridge

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO empty; byte counters 0; flash_address 0. Reset mid-transaction drops requests immediately (bridge returns to idle).
- States: IDLE, WR_STREAM, WR_WAIT, RD_STREAM, RD_DRAIN.
- IDLE: starts accepted only here; ignored otherwise. If dn_start and up_start coincide, dn_start wins and up_start is dropped.
- dn_start checks:
  - dn_length == 0: done pulse next cycle, no flash access.
  - dn_length > PAGE_SIZE or dn_block >= NUM_PAGES: error=1, done pulse, stay IDLE.
  - Otherwise: latch flash_address = BASE_PAGE + dn_block (16-bit) and length, clear error, assert flash_wr_request next cycle, enter WR_STREAM.
- WR_STREAM:
  - flash_wr_data_avail = dn_valid && (count < length); dn_ready = flash_wr_data_get; flash_wr_data = dn_data (combinational passthrough).
  - count increments on each get.
  - When count == length: deassert flash_wr_request, enter WR_WAIT.
- WR_WAIT:
  - Set seen flag when flash_wr_busy = 1.
  - Once seen && !flash_wr_busy: done pulse, go to IDLE.
  - Timeout: if busy is never seen within 8 cycles, error=1, done, IDLE.
- up_start:
  - up_length == 0, up_length > PAGE_SIZE, or up_block >= NUM_PAGES: error, done, IDLE.
  - Otherwise: latch address and length, assert flash_rd_request, enter RD_STREAM.
- RD_STREAM:
  - flash_rd_data_free = (fifo_count <= FIFO_DEPTH-2) && (rx_count < length). The two-entry margin absorbs the byte already in flight.
  - Each put writes the FIFO and increments rx_count.
  - Puts beyond length, or into a full FIFO, are discarded and set error.
  - When rx_count == length: drop flash_rd_request, enter RD_DRAIN.
- RD_DRAIN: when the FIFO is empty, done pulse, IDLE.
- up_valid = FIFO not empty; pop on up_valid && up_ready. Push and pop in the same cycle keep the count unchanged.

Test Plan:
- DNLOAD block 3, length 256, continuous dn_valid, bridge model with busy for 50 cycles -> flash_address=0x0203; exactly 256 gets, bytes in order; wr_request drops after byte 256; done one cycle after busy falls; error=0.
- DNLOAD length 100 with dn_valid toggling every other cycle -> exactly 100 bytes transferred; no get while dn_valid=0; done after busy falls.
- dn_length=0 -> done pulse next cycle, flash_wr_request never asserted. dn_block=0x0400 -> error=1, no flash access.
- UPLOAD block 0, length 16, up_ready low 20 cycles then high -> FIFO never overflows, rd_data_free low while FIFO holds >= FIFO_DEPTH-1 bytes; 16 bytes out in order; no 17th put requested; done after the last pop.
- dn_start and up_start in the same cycle -> write path taken, upload ignored. Reset asserted mid-WR_STREAM -> next cycle all outputs 0, state IDLE.
